// File: rtl/router_pkg.sv
// Shared router types: flit format, pipeline bus, port indices, port status and XY routing helpers.
package router_pkg;

   localparam int unsigned NUM_OF_PORTS = 5;
   localparam int unsigned COORD_W      = 4;
   localparam int unsigned PAYLOAD_W    = 16;

   localparam int unsigned LOCAL = 0;
   localparam int unsigned NORTH = 1;
   localparam int unsigned EAST  = 2;
   localparam int unsigned SOUTH = 3;
   localparam int unsigned WEST  = 4;

   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEAD_TAIL} flit_type_t;

   typedef enum logic [1:0] {IDLE, ACTIVE, FULL} PORT_STATUS_t;

   typedef struct packed {
      flit_type_t           flit_type;
      logic [COORD_W-1:0]   dst_x;
      logic [COORD_W-1:0]   dst_y;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   typedef struct packed {
      flit_t flit;
   } router_pipeline_bus_t;

   function automatic logic is_head(input flit_type_t t);
      return (t == HEAD) || (t == HEAD_TAIL);
   endfunction

   function automatic logic is_tail(input flit_type_t t);
      return (t == TAIL) || (t == HEAD_TAIL);
   endfunction

   // Dimension-ordered routing: resolve X first, then Y, else eject locally.
   function automatic logic [NUM_OF_PORTS-1:0] xy_route(
      input logic [COORD_W-1:0] dst_x,
      input logic [COORD_W-1:0] dst_y,
      input logic [COORD_W-1:0] cur_x,
      input logic [COORD_W-1:0] cur_y
   );
      logic [NUM_OF_PORTS-1:0] r;
      r = '0;
      if (dst_x > cur_x)      r[EAST]  = 1'b1;
      else if (dst_x < cur_x) r[WEST]  = 1'b1;
      else if (dst_y > cur_y) r[NORTH] = 1'b1;
      else if (dst_y < cur_y) r[SOUTH] = 1'b1;
      else                    r[LOCAL] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/input_fifo.sv
// Circular flit buffer with occupancy count; head is always visible on rd_data.
module input_fifo
   import router_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  flit_t            wr_data,
   input  logic             rd_en,
   output flit_t            rd_data,
   output logic [CNT_W-1:0] count
);

   flit_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             rd_ok;
   logic             wr_ok;

   // A pop in the same cycle frees the slot, so a full buffer may still accept.
   assign rd_ok   = rd_en && (count != '0);
   assign wr_ok   = wr_en && ((count != CNT_W'(DEPTH)) || rd_ok);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
         if (rd_ok) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
         count <= CNT_W'(count + CNT_W'(wr_ok) - CNT_W'(rd_ok));
      end
   end

endmodule

// File: rtl/input_unit.sv
// Router input port: req/ack link receiver, flit FIFO, XY route latch and switch request.
// Optional INPUT_UNIT_STATS_EN adds saturating capture and stall counters.
module input_unit
   import router_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ROUTER_X   = 0,
   parameter int unsigned ROUTER_Y   = 0,
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_upstream_req,
   input  router_pipeline_bus_t    i_u2i,
   output logic                    o_upstream_ack,
   input  logic                    i_switch_grant,
   output logic [NUM_OF_PORTS-1:0] o_switch_request,
   output router_pipeline_bus_t    o_i2s,
   output logic [CNT_W-1:0]        o_fifo_count,
   output PORT_STATUS_t            o_port_status
`ifdef INPUT_UNIT_STATS_EN
   ,
   output logic [31:0]             o_stat_flits_rx,
   output logic [31:0]             o_stat_stall_cycles
`endif
);

   typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT_LOW} rx_state_t;

   rx_state_t               state;
   flit_t                   head;
   logic [CNT_W-1:0]        count;
   logic                    empty;
   logic                    full;
   logic                    capture;
   logic                    pop;
   logic                    drop;
   logic                    route_valid;
   logic [NUM_OF_PORTS-1:0] route;
   logic                    route_valid_n;
   logic [NUM_OF_PORTS-1:0] route_n;
   logic [CNT_W-1:0]        count_n;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign capture = !reset && (state == RX_IDLE) && i_upstream_req && !full;
   assign pop     = i_switch_grant && !empty && route_valid;
   // A non-head flit at the head with no route latched has nowhere to go.
   assign drop    = !empty && !route_valid && !is_head(head.flit_type);

   input_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (capture),
      .wr_data (i_u2i.flit),
      .rd_en   (pop || drop),
      .rd_data (head),
      .count   (count)
   );

   assign o_fifo_count = count;

   // Next route and occupancy, used to register request and status coherently.
   always_comb begin
      route_valid_n = route_valid;
      route_n       = route;
      count_n       = count;
      if (pop && is_tail(head.flit_type)) begin
         route_valid_n = 1'b0;
         route_n       = '0;
      end else if (!route_valid && !empty && is_head(head.flit_type)) begin
         route_valid_n = 1'b1;
         route_n       = xy_route(head.dst_x, head.dst_y,
                                  COORD_W'(ROUTER_X), COORD_W'(ROUTER_Y));
      end
      if (capture && !(pop || drop))      count_n = CNT_W'(count + 1'b1);
      else if (!capture && (pop || drop)) count_n = CNT_W'(count - 1'b1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= RX_IDLE;
         o_upstream_ack   <= 1'b0;
         route_valid      <= 1'b0;
         route            <= '0;
         o_switch_request <= '0;
         o_i2s            <= '0;
         o_port_status    <= IDLE;
      end else begin
         o_upstream_ack <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (capture) begin
                  state          <= RX_ACK;
                  o_upstream_ack <= 1'b1;
               end
            end
            RX_ACK:      state <= RX_WAIT_LOW;
            RX_WAIT_LOW: if (!i_upstream_req) state <= RX_IDLE;
            default:     state <= RX_IDLE;
         endcase

         route_valid      <= route_valid_n;
         route            <= route_n;
         o_switch_request <= (route_valid_n && (count_n != '0)) ? route_n : '0;
         if (pop) o_i2s.flit <= head;

         if (count_n == CNT_W'(FIFO_DEPTH)) o_port_status <= FULL;
         else if (route_valid_n)            o_port_status <= ACTIVE;
         else                               o_port_status <= IDLE;
      end
   end

`ifdef INPUT_UNIT_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         o_stat_flits_rx     <= '0;
         o_stat_stall_cycles <= '0;
      end else begin
         if (capture && (o_stat_flits_rx != '1))
            o_stat_flits_rx <= o_stat_flits_rx + 32'd1;
         if ((state == RX_IDLE) && i_upstream_req && full && (o_stat_stall_cycles != '1))
            o_stat_stall_cycles <= o_stat_stall_cycles + 32'd1;
      end
   end
`endif

   orphan_body_a: assert property (@(posedge clk) disable iff (reset) !drop);

endmodule

// File: tb/tb_input_unit.sv
// Scenario bench for input_unit: expected flits queued at capture, checked when granted out.
module tb_input_unit;
   import router_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    i_upstream_req = 1'b0;
   router_pipeline_bus_t    i_u2i = '0;
   logic                    o_upstream_ack;
   logic                    i_switch_grant = 1'b0;
   logic [NUM_OF_PORTS-1:0] o_switch_request;
   router_pipeline_bus_t    o_i2s;
   logic [CW-1:0]           o_fifo_count;
   PORT_STATUS_t            o_port_status;
`ifdef INPUT_UNIT_STATS_EN
   logic [31:0]             o_stat_flits_rx;
   logic [31:0]             o_stat_stall_cycles;
`endif

   int    n_checks = 0;
   int    n_fail   = 0;
   flit_t exp_q[$];

   always #5 clk = ~clk;

   input_unit #(.FIFO_DEPTH(DEPTH), .ROUTER_X(1), .ROUTER_Y(1)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_upstream_req   (i_upstream_req),
      .i_u2i            (i_u2i),
      .o_upstream_ack   (o_upstream_ack),
      .i_switch_grant   (i_switch_grant),
      .o_switch_request (o_switch_request),
      .o_i2s            (o_i2s),
      .o_fifo_count     (o_fifo_count),
      .o_port_status    (o_port_status)
`ifdef INPUT_UNIT_STATS_EN
      ,
      .o_stat_flits_rx     (o_stat_flits_rx),
      .o_stat_stall_cycles (o_stat_stall_cycles)
`endif
   );

   function automatic flit_t mk(input flit_type_t t, input int x, input int y, input int p);
      flit_t f;
      f.flit_type = t;
      f.dst_x     = COORD_W'(x);
      f.dst_y     = COORD_W'(y);
      f.payload   = PAYLOAD_W'(p);
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one flit, wait (bounded) for ack, then release req long enough for the FSM to idle.
   task automatic send_flit(input flit_t f);
      bit got;
      got = 1'b0;
      i_u2i.flit     = f;
      i_upstream_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_upstream_ack) begin
            got = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL send_ack: no ack within 20 cycles for flit %h", f);
      end else begin
         exp_q.push_back(f);
      end
      i_upstream_req = 1'b0;
      tick();
      tick();
   endtask

   // Grant one cycle and compare the flit that leaves against the scoreboard.
   task automatic grant_check(input string tag);
      flit_t e;
      i_switch_grant = 1'b1;
      tick();
      i_switch_grant = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (o_i2s.flit !== e) begin
         n_fail++;
         $display("FAIL %s_i2s: got %h expected %h", tag, o_i2s.flit, e);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if (o_upstream_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", o_upstream_ack); end
      n_checks++;
      if (o_switch_request !== 5'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 00000", o_switch_request); end
      n_checks++;
      if (o_i2s !== '0) begin n_fail++; $display("FAIL rst_i2s: got %h expected 0", o_i2s); end
      n_checks++;
      if (o_fifo_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", o_fifo_count); end
      n_checks++;
      if (o_port_status !== IDLE) begin n_fail++; $display("FAIL rst_status: got %0d expected IDLE", o_port_status); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_handshake();
      flit_t f;
      f = mk(HEAD_TAIL, 2, 1, 16'hA001);
      i_u2i.flit     = f;
      i_upstream_req = 1'b1;
      tick();
      n_checks++;
      if (o_upstream_ack !== 1'b1) begin n_fail++; $display("FAIL hs_ack: got %b expected 1", o_upstream_ack); end
      n_checks++;
      if (o_fifo_count !== CW'(1)) begin n_fail++; $display("FAIL hs_count: got %0d expected 1", o_fifo_count); end
      exp_q.push_back(f);
      i_upstream_req = 1'b0;
      tick();
      n_checks++;
      if (o_upstream_ack !== 1'b0) begin n_fail++; $display("FAIL hs_ack_pulse: got %b expected 0", o_upstream_ack); end
      n_checks++;
      if (o_switch_request !== 5'b00100) begin n_fail++; $display("FAIL hs_req: got %b expected 00100", o_switch_request); end
      n_checks++;
      if (o_port_status !== ACTIVE) begin n_fail++; $display("FAIL hs_status: got %0d expected ACTIVE", o_port_status); end
      tick();
      grant_check("hs");
      n_checks++;
      if (o_switch_request !== 5'b0) begin n_fail++; $display("FAIL hs_req_drop: got %b expected 00000", o_switch_request); end
      n_checks++;
      if (o_fifo_count !== '0) begin n_fail++; $display("FAIL hs_count_end: got %0d expected 0", o_fifo_count); end
      n_checks++;
      if (o_port_status !== IDLE) begin n_fail++; $display("FAIL hs_status_end: got %0d expected IDLE", o_port_status); end
   endtask

   task automatic test_routes();
      int               dx [4] = '{1, 0, 1, 1};
      int               dy [4] = '{1, 1, 2, 0};
      logic [4:0]       exp_r [4] = '{5'b00001, 5'b10000, 5'b00010, 5'b01000};
      for (int i = 0; i < 4; i++) begin
         send_flit(mk(HEAD_TAIL, dx[i], dy[i], 16'hB000 + i));
         n_checks++;
         if (o_switch_request !== exp_r[i]) begin
            n_fail++;
            $display("FAIL route_%0d: got %b expected %b", i, o_switch_request, exp_r[i]);
         end
         grant_check("route");
         n_checks++;
         if (o_switch_request !== 5'b0) begin n_fail++; $display("FAIL route_drop_%0d: got %b expected 00000", i, o_switch_request); end
      end
   endtask

   task automatic test_full();
      flit_t f5;
      bit    got;
      send_flit(mk(HEAD, 2, 1, 16'hC000));
      send_flit(mk(BODY, 0, 0, 16'hC001));
      send_flit(mk(BODY, 0, 0, 16'hC002));
      send_flit(mk(BODY, 0, 0, 16'hC003));
      n_checks++;
      if (o_port_status !== FULL) begin n_fail++; $display("FAIL full_status: got %0d expected FULL", o_port_status); end
      f5 = mk(TAIL, 0, 0, 16'hC004);
      i_u2i.flit     = f5;
      i_upstream_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (o_upstream_ack !== 1'b0) begin n_fail++; $display("FAIL full_stall_ack_%0d: got %b expected 0", i, o_upstream_ack); end
      end
      n_checks++;
      if (o_fifo_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", o_fifo_count, DEPTH); end
      grant_check("full_head");
      got = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (o_upstream_ack) begin
            got = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL full_release_ack: got no ack expected ack within 2 cycles"); end
      else exp_q.push_back(f5);
      i_upstream_req = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         grant_check("full_drain");
         n_checks++;
         if (o_switch_request !== ((i < 3) ? 5'b00100 : 5'b00000)) begin
            n_fail++;
            $display("FAIL full_drain_req_%0d: got %b expected %b", i, o_switch_request,
                     (i < 3) ? 5'b00100 : 5'b00000);
         end
      end
   endtask

   task automatic test_packet_hold();
      send_flit(mk(HEAD, 1, 2, 16'hD000));
      send_flit(mk(BODY, 0, 0, 16'hD001));
      send_flit(mk(BODY, 3, 3, 16'hD002));
      send_flit(mk(TAIL, 0, 5, 16'hD003));
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (o_switch_request !== 5'b00010) begin
            n_fail++;
            $display("FAIL hold_req_%0d: got %b expected 00010", i, o_switch_request);
         end
         grant_check("hold");
      end
      n_checks++;
      if (o_switch_request !== 5'b0) begin n_fail++; $display("FAIL hold_req_drop: got %b expected 00000", o_switch_request); end
   endtask

   task automatic test_held_req();
      flit_t f;
      int    acks;
      f = mk(HEAD_TAIL, 1, 1, 16'hE000);
      acks = 0;
      i_u2i.flit     = f;
      i_upstream_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (o_upstream_ack) acks++;
      end
      i_upstream_req = 1'b0;
      tick();
      tick();
      exp_q.push_back(f);
      n_checks++;
      if (acks != 1) begin n_fail++; $display("FAIL held_acks: got %0d expected 1", acks); end
      n_checks++;
      if (o_fifo_count !== CW'(1)) begin n_fail++; $display("FAIL held_count: got %0d expected 1", o_fifo_count); end
      grant_check("held");
   endtask

   task automatic test_reset_mid();
      flit_t f;
      send_flit(mk(HEAD, 2, 1, 16'hF000));
      send_flit(mk(BODY, 0, 0, 16'hF001));
      send_flit(mk(BODY, 0, 0, 16'hF002));
      n_checks++;
      if (o_fifo_count !== CW'(3)) begin n_fail++; $display("FAIL mid_count_pre: got %0d expected 3", o_fifo_count); end
      f = mk(HEAD_TAIL, 1, 0, 16'hF0AA);
      i_u2i.flit     = f;
      i_upstream_req = 1'b1;
      reset          = 1'b1;
      tick();
      exp_q.delete();
      n_checks++;
      if (o_fifo_count !== '0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", o_fifo_count); end
      n_checks++;
      if (o_switch_request !== 5'b0) begin n_fail++; $display("FAIL mid_req: got %b expected 00000", o_switch_request); end
      n_checks++;
      if (o_port_status !== IDLE) begin n_fail++; $display("FAIL mid_status: got %0d expected IDLE", o_port_status); end
`ifdef INPUT_UNIT_STATS_EN
      n_checks++;
      if (o_stat_flits_rx !== 32'd0) begin n_fail++; $display("FAIL mid_stat_rx: got %0d expected 0", o_stat_flits_rx); end
      n_checks++;
      if (o_stat_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_stat_stall: got %0d expected 0", o_stat_stall_cycles); end
`endif
      reset = 1'b0;
      tick();
      n_checks++;
      if (o_upstream_ack !== 1'b1) begin n_fail++; $display("FAIL mid_recapture_ack: got %b expected 1", o_upstream_ack); end
      exp_q.push_back(f);
      i_upstream_req = 1'b0;
      tick();
      tick();
      n_checks++;
      if (o_switch_request !== 5'b01000) begin n_fail++; $display("FAIL mid_req_south: got %b expected 01000", o_switch_request); end
      grant_check("mid");
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_routes();
      test_full();
      test_packet_hold();
      test_held_req();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/input_unit.md
Name: input_unit

Overview:
- Receive side of the router-to-router link: accepts flits from the upstream output stage over the req/ack handshake and buffers them in a FIFO.
- Computes the XY route on each head flit and raises a one-hot switch request toward the switch allocator.
- Holds that route until the packet's tail flit leaves on a switch grant.
- Sits between the link input pins and the crossbar/switch allocator, one instance per router port.

Parameters:
- FIFO_DEPTH, 4, flit buffer entries; power of 2, minimum 2.
- ROUTER_X, 0, this router's X coordinate.
- ROUTER_Y, 0, this router's Y coordinate.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- i_upstream_req  input  1  upstream holds a valid flit on i_u2i
- i_u2i  input  router_pipeline_bus_t  incoming flit bus
- o_upstream_ack  output  1  one-cycle pulse: flit captured
- i_switch_grant  input  1  allocator grants this unit's current request; flit leaves this cycle
- o_switch_request  output  NUM_OF_PORTS  one-hot requested output port
- o_i2s  output  router_pipeline_bus_t  FIFO head flit to crossbar
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
- o_port_status  output  PORT_STATUS_t  IDLE / ACTIVE (packet in flight) / FULL

Behaviour:
- Interface timing: one clock; reset synchronous and active-high. All outputs are registered.
- Reset values: o_upstream_ack=0, o_switch_request=0, o_i2s=0, o_fifo_count=0, o_port_status=IDLE. FIFO pointers, route register and handshake FSM are all cleared.
- Handshake FSM states: RX_IDLE, RX_ACK, RX_WAIT_LOW.
  - RX_IDLE: if i_upstream_req=1 and FIFO not full, write i_u2i.flit into the FIFO and go to RX_ACK. If the FIFO is full, stay in RX_IDLE; req stays pending and no ack is issued.
  - RX_ACK: o_upstream_ack=1 for exactly this cycle; go to RX_WAIT_LOW.
  - RX_WAIT_LOW: wait for i_upstream_req=0, then go to RX_IDLE. A held req is never captured twice.
  - Capture-to-ack latency: 1 cycle. Minimum spacing between flits: 3 cycles.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH; full and empty are derived from o_fifo_count.
  - A write and a read in the same cycle leave the count unchanged. This is legal when full (a read frees the slot) and when empty only if the write is not the flit being read; there is no bypass, so a freshly written flit is visible on o_i2s the next cycle.
- Route compute (on the FIFO head, when it is a head flit and no route is latched):
  - dst_x>ROUTER_X → EAST; dst_x<ROUTER_X → WEST.
  - Otherwise dst_y>ROUTER_Y → NORTH; dst_y<ROUTER_Y → SOUTH; else LOCAL.
  - The result is latched in the route register. o_switch_request is asserted one cycle after the head flit reaches the FIFO head and stays asserted while the FIFO is non-empty and the route is latched.
- Switch traversal:
  - On i_switch_grant with a non-empty FIFO: pop the head; o_i2s is registered with the popped flit on the next cycle.
  - If the popped flit is a tail (or head+tail single-flit packet): clear the route register and drop o_switch_request the next cycle.
  - A grant while the FIFO is empty is ignored.
  - Body flits never recompute the route. A body flit arriving with no route latched is dropped and treated as a protocol error (assertion).
- o_port_status: FULL when count=FIFO_DEPTH, else ACTIVE when a route is latched, else IDLE.
- Reset mid-packet discards all buffered flits and the route. An upstream req held across reset is captured afresh in RX_IDLE.

Optional Feature:
- Macro: INPUT_UNIT_STATS_EN.
- Defined: adds 32-bit saturating counters, cleared on reset.
  - o_stat_flits_rx: increments on each capture.
  - o_stat_stall_cycles: increments each cycle i_upstream_req=1 while the FIFO is full in RX_IDLE.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- router_pkg additions:
  - flit_type_t (HEAD, BODY, TAIL, HEAD_TAIL).
  - Header dst_x/dst_y fields within the flit type.
  - Port index constants LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - Reuse NUM_OF_PORTS, router_pipeline_bus_t and PORT_STATUS_t (add FULL if missing).
- Sub-module: input_fifo, a parameterized circular flit buffer with count.
- The FSM and XY route logic stay in input_unit.

Test Plan:
- Handshake: with ROUTER_X=1, ROUTER_Y=1 and an empty FIFO, raise req with a single HEAD_TAIL flit dst (2,1), holding req until ack → ack is one pulse 1 cycle after capture; o_fifo_count=1; o_switch_request=5'b00100 (EAST); after grant, the flit appears on o_i2s and the request drops.
- Route coverage: inject dst (1,1), (0,1), (1,2), (1,0) → LOCAL, WEST, NORTH, SOUTH one-hot respectively.
- Full FIFO: with FIFO_DEPTH=4 and no grants, send 5 flits → 4 acks, 5th req stalls with ack=0 and status FULL. One grant → the 5th flit is captured and acked within 2 cycles.
- Packet hold: send a 4-flit packet whose body flits carry garbage dst fields → all 4 flits are routed to the head's port; the request drops only after the tail grant.
- Req held high for 10 cycles → exactly one capture and one ack.
- Reset mid-packet: assert reset with 3 flits buffered → count=0, request=0, status IDLE next cycle. With INPUT_UNIT_STATS_EN defined, stats read 0.
